// File: rtl/arb_pkg.sv
// Shared constants and state type for the round-robin arbiter.
// Imported by rr_arbiter8; rr_pick takes its defaults from here.
package arb_pkg;

  localparam int N = 8;
  localparam int IDW = $clog2(N);
  localparam int MAX_HOLD_DEF = 15;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set bit of req at or after ptr, wrapping.
// Ports: req, ptr in; id (winner), found (req != 0) out; id=0 if none.
module rr_pick #(
  parameter int N   = arb_pkg::N,
  parameter int IDW = arb_pkg::IDW
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] id,
  output logic           found
);

  logic [IDW-1:0] idx;

  // Scan furthest offset first so the nearest hit is written last.
  always_comb begin
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        id    = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with hold-until-release and hold timeout.
// Ports: clk, rst, en, req, rel in; gnt, gnt_id, gnt_valid, timeout out.
module rr_arbiter8 #(
  parameter int N        = arb_pkg::N,
  parameter int IDW      = arb_pkg::IDW,
  parameter int MAX_HOLD = arb_pkg::MAX_HOLD_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  // owner is finished; "release" itself is a reserved word
  input  logic           rel,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  import arb_pkg::*;

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] LAST =
    (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [IDW-1:0] TOP = IDW'(N - 1);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;
  logic [IDW-1:0] pick_id;
  logic           found;
  logic           stop;
  logic           expire;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .id    (pick_id),
    .found (found)
  );

  // Owner-side reasons to end; these override the timeout pulse.
  assign stop   = rel | ~req[gnt_id] | ~en;
  assign expire = (MAX_HOLD != 0) && (hold_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && found) begin
            gnt       <= ONE << pick_id;
            gnt_id    <= pick_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (stop || expire) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= ~stop;
            ptr       <= (gnt_id == TOP) ? '0 : gnt_id + 1'b1;
            state     <= IDLE;
          end else if (MAX_HOLD != 0) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  a_gnt_id : assert property (@(posedge clk) disable iff (rst)
    gnt == (gnt_valid ? (ONE << gnt_id) : '0));
  a_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt));
  a_busy : assert property (@(posedge clk) disable iff (rst)
    gnt_valid |-> state == BUSY);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized + directed bench for rr_arbiter8 against a behavioural model.
// Model tracks owner, pointer and cycles-held as plain integers.
module tb_rr_arbiter8;

  localparam int N  = 8;
  localparam int IDW = 3;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           rel;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;

  always #5 clk = ~clk;

  rr_arbiter8 #(
    .N        (N),
    .IDW      (IDW),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  int errs   = 0;
  int checks = 0;

  int owner = -1;
  int mptr  = 0;
  int held  = 0;
  bit mto   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit l,
                       input logic [N-1:0] q);
    if (r) begin
      owner = -1;
      mptr  = 0;
      held  = 0;
      mto   = 1'b0;
    end else if (owner < 0) begin
      mto = 1'b0;
      if (e && q != '0) begin
        for (int k = 0; k < N; k++) begin
          if (q[(mptr + k) % N]) begin
            owner = (mptr + k) % N;
            break;
          end
        end
        held = 1;
      end
    end else begin
      bit ends;
      bit tmo;
      ends = l || !q[owner] || !e;
      tmo  = (MH != 0) && (held == MH);
      if (ends || tmo) begin
        mto   = !ends;
        mptr  = (owner + 1) % N;
        owner = -1;
      end else begin
        held++;
        mto = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit l,
                      input logic [N-1:0] q);
    logic [31:0] xg;
    rst = r;
    en  = e;
    rel = l;
    req = q;
    @(posedge clk);
    model(r, e, l, q);
    #1;
    xg = (owner < 0) ? 32'd0 : (32'd1 << owner);
    chk("gnt_valid", 32'(gnt_valid), 32'(owner >= 0));
    chk("gnt_id", 32'(gnt_id), (owner < 0) ? 32'd0 : 32'(owner));
    chk("gnt", 32'(gnt), xg);
    chk("timeout", 32'(timeout), 32'(mto));
  endtask

  initial begin
    logic [N-1:0] q;
    rst = 1'b1;
    en  = 1'b1;
    rel = 1'b0;
    req = 8'hFF;

    // reset with full contention, then first grant to id 0
    step(1, 1, 0, 8'hFF);
    step(1, 1, 0, 8'hFF);
    step(0, 1, 0, 8'hFF);
    chk("first_id", 32'(gnt_id), 32'd0);
    step(0, 1, 1, 8'hFF);

    // rotation between 2 and 7 with wrap
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'h84);
      chk("rot_id", 32'(gnt_id), (i % 2 == 0) ? 32'd2 : 32'd7);
      step(0, 1, 1, 8'h84);
      chk("rot_bubble", 32'(gnt_valid), 32'd0);
    end

    // full contention, release every grant
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0, 8'hFF);
      chk("full_gnt", 32'(gnt), 32'd1 << (i % 8));
      step(0, 1, 1, 8'hFF);
    end

    // timeout with a single persistent requester
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 8'h08);
      if (i == 4 || i == 9) chk("to_pulse", 32'(timeout), 32'd1);
    end
    step(0, 1, 1, 8'h08);

    // request drop
    step(0, 1, 0, 8'h20);
    chk("drop_id", 32'(gnt_id), 32'd5);
    step(0, 1, 0, 8'h00);
    chk("drop_to", 32'(timeout), 32'd0);
    step(0, 1, 0, 8'h21);
    chk("drop_next", 32'(gnt_id), 32'd0);
    step(0, 1, 1, 8'h21);

    // disable, then reset during a grant
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'hFF);
    step(0, 1, 0, 8'h01);
    step(1, 1, 0, 8'hFF);
    step(0, 1, 0, 8'hFF);
    chk("post_rst_id", 32'(gnt_id), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: q = 8'(1 << $urandom_range(0, N - 1));
        1: q = 8'hFF;
        default: q = 8'($urandom);
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, q);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
